// File: rtl/multicycle_mainfsm_if.sv
// Controller <-> datapath/memory bundle for the multicycle main FSM.
// master: the sequencing FSM (consumes instruction fields and MemReady,
// drives selects and strobes). slave: datapath/memory side.
interface multicycle_mainfsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       MemReq;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ALUOp;
  logic       FlagEn;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       Fault;
  logic [3:0] State;

  modport master (
    input  Op, Funct, MemReady,
    output MemReq, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           ALUOp, FlagEn, NextPC, RegW, MemW, Branch, Fault, State
  );

  modport slave (
    output Op, Funct, MemReady,
    input  MemReq, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           ALUOp, FlagEn, NextPC, RegW, MemW, Branch, Fault, State
  );
endinterface

// File: rtl/multicycle_mainfsm.sv
// Main sequencing FSM of the multicycle ARM controller.
// Steps each instruction through fetch/decode/execute/memory/writeback,
// drives datapath selects and raw write strobes, and guards every memory
// state with a bounded wait on MemReady that traps to a sticky FAULT.
module multicycle_mainfsm #(
  parameter int unsigned WAIT_MAX = 15
) (
  input logic                   clk,
  input logic                   reset,
  multicycle_mainfsm_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    FAULT    = 4'd10
  } state_t;

  localparam logic [7:0] WMAX = 8'(WAIT_MAX);

  state_t     state, state_n;
  logic [7:0] wcnt, wcnt_n;
  logic       is_mem;
  logic       timeout;

  logic       mem_req, ir_write, adr_src, alu_src_a, alu_op, flag_en;
  logic       next_pc, reg_w, mem_w, branch, fault;
  logic [1:0] alu_src_b, result_src;

  // Funct[4:1] are decoded elsewhere; only I and S/L steer the sequence.
  logic funct_unused;
  assign funct_unused = ^bus.Funct[4:1];

  assign is_mem  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign timeout = is_mem && !bus.MemReady && (wcnt == WMAX);

  // State and wait-counter registers, asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
    end
  end

  // Next-state sequencing; the watchdog overrides a held memory state.
  always_comb begin
    state_n = state;
    case (state)
      FETCH:    if (bus.MemReady) state_n = DECODE;
      DECODE: begin
        case (bus.Op)
          2'b00:   state_n = bus.Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_n = MEMADR;
          2'b10:   state_n = BRANCH;
          default: state_n = FAULT;
        endcase
      end
      MEMADR:   state_n = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:    if (bus.MemReady) state_n = MEMWB;
      MEMWR:    if (bus.MemReady) state_n = FETCH;
      MEMWB:    state_n = FETCH;
      EXECUTER: state_n = ALUWB;
      EXECUTEI: state_n = ALUWB;
      ALUWB:    state_n = FETCH;
      BRANCH:   state_n = FETCH;
      FAULT:    state_n = FAULT;
      default:  state_n = FAULT;
    endcase
    if (timeout) state_n = FAULT;
  end

  // Wait counter: counts only while a memory state is held; any entry
  // (including MEMWR->FETCH) or non-memory state restarts it from zero.
  always_comb begin
    wcnt_n = '0;
    if (is_mem && (state_n == state)) begin
      wcnt_n = (wcnt == WMAX) ? wcnt : wcnt + 8'd1;
    end
  end

  // Output decode from the current state; selects default to 0.
  always_comb begin
    mem_req    = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 1'b0;
    flag_en    = 1'b0;
    next_pc    = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    fault      = 1'b0;
    case (state)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.MemReady;
        next_pc    = bus.MemReady;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      MEMADR: begin
        alu_src_b  = 2'b01;
      end
      MEMRD: begin
        mem_req    = 1'b1;
        adr_src    = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      MEMWR: begin
        mem_req    = 1'b1;
        adr_src    = 1'b1;
        mem_w      = 1'b1;
      end
      EXECUTER: begin
        alu_op     = 1'b1;
        flag_en    = 1'b1;
      end
      EXECUTEI: begin
        alu_src_b  = 2'b01;
        alu_op     = 1'b1;
        flag_en    = 1'b1;
      end
      ALUWB: begin
        reg_w      = 1'b1;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
      end
      FAULT: begin
        fault      = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset directly so they drop the instant reset
  // asserts, independent of the register's asynchronous clear.
  assign bus.MemReq    = mem_req  & reset;
  assign bus.IRWrite   = ir_write & reset;
  assign bus.NextPC    = next_pc  & reset;
  assign bus.RegW      = reg_w    & reset;
  assign bus.MemW      = mem_w    & reset;
  assign bus.Branch    = branch   & reset;
  assign bus.AdrSrc    = adr_src;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ResultSrc = result_src;
  assign bus.ALUOp     = alu_op;
  assign bus.FlagEn    = flag_en;
  assign bus.Fault     = fault;
  assign bus.State     = state;

endmodule

// File: tb/tb_multicycle_mainfsm.sv
// Bench for multicycle_mainfsm: a cycle model of the instruction sequencer
// is checked against the DUT on every falling edge, alongside directed
// instruction sequences with literal state/strobe expectations.
module tb_multicycle_mainfsm;
  localparam int WM = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nvec = 0;
  int   nmis = 0;

  // Model state: current state code and consecutive memory wait cycles.
  int ms = 0;
  int held = 0;

  multicycle_mainfsm_if bif();

  multicycle_mainfsm #(.WAIT_MAX(WM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  logic [18:0] dut_o;
  assign dut_o = {bif.State, bif.MemReq, bif.IRWrite, bif.AdrSrc, bif.ALUSrcA,
                  bif.ALUSrcB, bif.ResultSrc, bif.ALUOp, bif.FlagEn,
                  bif.NextPC, bif.RegW, bif.MemW, bif.Branch, bif.Fault};

  logic [6:0] dut_stb;
  assign dut_stb = {bif.MemReq, bif.IRWrite, bif.NextPC, bif.RegW,
                    bif.MemW, bif.Branch, bif.Fault};

  // Expected outputs for a state code, from the per-state output table.
  function automatic logic [18:0] model_out(int s, logic rdy, logic rn);
    logic       mreq, ir, adr, asa, aop, fen, npc, rw, mw, br, flt;
    logic [1:0] asb, rsrc;
    mreq = s inside {0, 3, 5};
    adr  = s inside {3, 5};
    asa  = s inside {0, 1};
    asb  = (s inside {0, 1}) ? 2'd2 : (s inside {2, 7, 9}) ? 2'd1 : 2'd0;
    rsrc = (s inside {0, 1, 9}) ? 2'd2 : (s == 4) ? 2'd1 : 2'd0;
    aop  = s inside {6, 7};
    fen  = aop;
    rw   = s inside {4, 8};
    mw   = (s == 5);
    br   = (s == 9);
    flt  = (s == 10);
    ir   = (s == 0) && rdy;
    npc  = ir;
    if (!rn) {mreq, ir, npc, rw, mw, br} = '0;
    return {4'(s), mreq, ir, adr, asa, asb, rsrc, aop, fen, npc, rw, mw, br, flt};
  endfunction

  // Instruction-flow rules (ignoring the watchdog).
  function automatic int model_next(int s, logic [1:0] op, logic [5:0] f, logic rdy);
    case (s)
      0:       return rdy ? 1 : 0;
      1: begin
        if (op == 2'b01) return 2;
        if (op == 2'b00) return f[5] ? 7 : 6;
        if (op == 2'b10) return 9;
        return 10;
      end
      2:       return f[0] ? 3 : 5;
      3:       return rdy ? 4 : 3;
      5:       return rdy ? 0 : 5;
      4, 8, 9: return 0;
      6, 7:    return 8;
      default: return 10;
    endcase
  endfunction

  always @(posedge clk) begin
    int nx;
    if (!reset) begin
      ms   = 0;
      held = 0;
    end else begin
      nx = model_next(ms, bif.Op, bif.Funct, bif.MemReady);
      if ((ms inside {0, 3, 5}) && nx == ms) begin
        if (held == WM) nx = 10;
        else            held++;
      end
      if (nx != ms) held = 0;
      ms = nx;
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    logic [18:0] e;
    if (!reset) begin
      ms   = 0;
      held = 0;
    end
    e = model_out(ms, bif.MemReady, reset);
    nvec++;
    if (dut_o !== e) begin
      nmis++;
      $display("FAIL model_cycle t=%0t got=%h exp=%h", $time, dut_o, e);
    end
  end

  task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s t=%0t got state=%0d stb=%b exp state=%0d stb=%b",
               nm, $time, act[10:7], act[6:0], exp[10:7], exp[6:0]);
    end
  endtask

  // One cycle: drive inputs (at posedge+1), check literal state and
  // strobes {MemReq,IRWrite,NextPC,RegW,MemW,Branch,Fault} at negedge.
  task automatic cyc(input logic rdy, input logic [1:0] op, input logic [5:0] f,
                     input logic [3:0] es, input logic [6:0] estb, input string nm);
    bif.MemReady = rdy;
    bif.Op       = op;
    bif.Funct    = f;
    @(negedge clk);
    check(nm, {bif.State, dut_stb}, {es, estb});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  localparam logic [6:0] S_FETCH = 7'b1110000;
  localparam logic [6:0] S_WAIT  = 7'b1000000;
  localparam logic [6:0] S_NONE  = 7'b0000000;
  localparam logic [6:0] S_REGW  = 7'b0001000;
  localparam logic [6:0] S_STR   = 7'b1000100;
  localparam logic [6:0] S_BR    = 7'b0000010;
  localparam logic [6:0] S_FLT   = 7'b0000001;

  initial begin
    bif.MemReady = 1'b0;
    bif.Op       = 2'b00;
    bif.Funct    = 6'b000000;
    do_reset();

    // Data-processing register form: 0,1,6,8
    cyc(1, 2'b00, 6'b000000, 4'd0, S_FETCH, "dp_fetch");
    cyc(1, 2'b00, 6'b000000, 4'd1, S_NONE,  "dp_decode");
    cyc(1, 2'b00, 6'b000000, 4'd6, S_NONE,  "dp_execr");
    cyc(1, 2'b00, 6'b000000, 4'd8, S_REGW,  "dp_aluwb");
    // Data-processing immediate form: 0,1,7,8
    cyc(1, 2'b00, 6'b100000, 4'd0, S_FETCH, "dpi_fetch");
    cyc(1, 2'b00, 6'b100000, 4'd1, S_NONE,  "dpi_decode");
    cyc(1, 2'b00, 6'b100000, 4'd7, S_NONE,  "dpi_execi");
    cyc(1, 2'b00, 6'b100000, 4'd8, S_REGW,  "dpi_aluwb");
    // LDR with two wait cycles in MEMRD: 0,1,2,3,3,3,4
    cyc(1, 2'b01, 6'b011001, 4'd0, S_FETCH, "ldr_fetch");
    cyc(1, 2'b01, 6'b011001, 4'd1, S_NONE,  "ldr_decode");
    cyc(1, 2'b01, 6'b011001, 4'd2, S_NONE,  "ldr_memadr");
    cyc(0, 2'b01, 6'b011001, 4'd3, S_WAIT,  "ldr_memrd0");
    cyc(0, 2'b01, 6'b011001, 4'd3, S_WAIT,  "ldr_memrd1");
    cyc(1, 2'b01, 6'b011001, 4'd3, S_WAIT,  "ldr_memrd2");
    cyc(1, 2'b01, 6'b011001, 4'd4, S_REGW,  "ldr_memwb");
    // STR: 0,1,2,5
    cyc(1, 2'b01, 6'b011000, 4'd0, S_FETCH, "str_fetch");
    cyc(1, 2'b01, 6'b011000, 4'd1, S_NONE,  "str_decode");
    cyc(1, 2'b01, 6'b011000, 4'd2, S_NONE,  "str_memadr");
    cyc(1, 2'b01, 6'b011000, 4'd5, S_STR,   "str_memwr");
    // B: 0,1,9
    cyc(1, 2'b10, 6'b000000, 4'd0, S_FETCH, "b_fetch");
    cyc(1, 2'b10, 6'b000000, 4'd1, S_NONE,  "b_decode");
    cyc(1, 2'b10, 6'b000000, 4'd9, S_BR,    "b_branch");
    // Op=11 in DECODE traps
    cyc(1, 2'b11, 6'b000000, 4'd0, S_FETCH, "op11_fetch");
    cyc(1, 2'b11, 6'b000000, 4'd1, S_NONE,  "op11_decode");
    cyc(1, 2'b11, 6'b000000, 4'd10, S_FLT,  "op11_fault");
    cyc(1, 2'b00, 6'b000000, 4'd10, S_FLT,  "op11_sticky");
    do_reset();

    // Watchdog in FETCH: four waiting cycles, then sticky FAULT
    for (int i = 0; i < 4; i++) cyc(0, 2'b00, 6'b000000, 4'd0, S_WAIT, "wd_fetch_wait");
    cyc(0, 2'b00, 6'b000000, 4'd10, S_FLT, "wd_fetch_fault");
    cyc(1, 2'b01, 6'b011001, 4'd10, S_FLT, "wd_sticky_ldr");
    cyc(1, 2'b10, 6'b111111, 4'd10, S_FLT, "wd_sticky_b");
    cyc(0, 2'b00, 6'b000000, 4'd10, S_FLT, "wd_sticky_idle");
    do_reset();

    // Ready arriving exactly when the count reaches WAIT_MAX wins
    for (int i = 0; i < 3; i++) cyc(0, 2'b00, 6'b000000, 4'd0, S_WAIT, "bnd_wait");
    cyc(1, 2'b00, 6'b000000, 4'd0, S_FETCH, "bnd_ready");
    cyc(1, 2'b00, 6'b000000, 4'd1, S_NONE,  "bnd_decode");
    cyc(1, 2'b00, 6'b000000, 4'd6, S_NONE,  "bnd_execr");
    cyc(1, 2'b00, 6'b000000, 4'd8, S_REGW,  "bnd_aluwb");

    // Watchdog in MEMWR
    cyc(1, 2'b01, 6'b011000, 4'd0, S_FETCH, "wdw_fetch");
    cyc(1, 2'b01, 6'b011000, 4'd1, S_NONE,  "wdw_decode");
    cyc(1, 2'b01, 6'b011000, 4'd2, S_NONE,  "wdw_memadr");
    for (int i = 0; i < 4; i++) cyc(0, 2'b01, 6'b011000, 4'd5, S_STR, "wdw_memwr");
    cyc(0, 2'b01, 6'b011000, 4'd10, S_FLT, "wdw_fault");
    do_reset();

    // Asynchronous reset in the middle of a held MEMWR
    cyc(1, 2'b01, 6'b011000, 4'd0, S_FETCH, "ar_fetch");
    cyc(1, 2'b01, 6'b011000, 4'd1, S_NONE,  "ar_decode");
    cyc(1, 2'b01, 6'b011000, 4'd2, S_NONE,  "ar_memadr");
    cyc(0, 2'b01, 6'b011000, 4'd5, S_STR,   "ar_memwr");
    #2 reset = 1'b0;
    #1 check("ar_async", {bif.State, dut_stb}, {4'd0, S_NONE});
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cyc(1, 2'b00, 6'b000000, 4'd0, S_FETCH, "ar_refetch");
    cyc(1, 2'b00, 6'b000000, 4'd1, S_NONE,  "ar_redecode");

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/multicycle_mainfsm.md
Name: multicycle_mainfsm

Overview:
- Main sequencing state machine of the multicycle ARM controller.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath mux selects and raw write strobes (RegW, MemW, NextPC, Branch). Condition gating of those strobes is done downstream by the condition-check/flag logic.
- Adds a memory ready handshake with a bounded-wait watchdog that traps to a sticky FAULT state.

Parameters:
- WAIT_MAX, 15: maximum consecutive cycles a memory state may wait for MemReady before trapping to FAULT (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Op  input  2  instr[27:26].
- Funct  input  6  instr[25:20]; Funct[5]=I (immediate), Funct[0]=S/L.
- MemReady  input  1  memory completes the current access this cycle.
- MemReq  output  1  memory access request.
- IRWrite  output  1  instruction register load.
- AdrSrc  output  1  0 = PC, 1 = ALUOut/Result.
- ALUSrcA  output  1  0 = register A, 1 = PC.
- ALUSrcB  output  2  00 = register, 01 = ExtImm, 10 = constant 4.
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUOp  output  1  ALU decoder enable (data-processing op).
- FlagEn  output  1  flag-write window; the decoder ANDs this into FlagW.
- NextPC  output  1  PC increment write.
- RegW  output  1  raw register write.
- MemW  output  1  raw memory write.
- Branch  output  1  raw branch (PCS source).
- Fault  output  1  sticky fault indicator.
- State  output  4  current state encoding, for debug.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, FAULT=10.
- Codes 11–15 are illegal and go to FAULT on the next clock.
- Reset (reset=0, asynchronous): state=FETCH, wait counter=0, Fault=0.
  - While reset=0, MemReq, IRWrite, NextPC, RegW, MemW and Branch are forced to 0.
  - Other outputs take their FETCH values.
- Outputs are decoded from the state; all unlisted outputs are 0 and all selects default to 0.
  - FETCH: MemReq=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10. IRWrite and NextPC are 1 only in the cycle MemReady=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMRD: MemReq=1, AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: MemReq=1, AdrSrc=1, ResultSrc=00, MemW=1 for every cycle held.
  - EXECUTER: ALUSrcB=00, ALUOp=1, FlagEn=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1, FlagEn=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
  - FAULT: Fault=1, all strobes 0.
- Transitions:
  - FETCH→DECODE when MemReady=1; otherwise stay.
  - DECODE: Op=01→MEMADR; Op=00 with Funct[5]=0→EXECUTER; Op=00 with Funct[5]=1→EXECUTEI; Op=10→BRANCH; Op=11→FAULT.
  - MEMADR: Funct[0]=1→MEMRD, else→MEMWR.
  - MEMRD→MEMWB when MemReady=1; otherwise stay.
  - MEMWR→FETCH when MemReady=1; otherwise stay.
  - MEMWB, ALUWB and BRANCH→FETCH.
  - EXECUTER and EXECUTEI→ALUWB.
  - FAULT→FAULT; exit only via reset.
- Op and Funct are sampled every cycle; the IR is stable from DECODE onward.
- Fixed latencies with MemReady=1 on first request:
  - data-processing: 4 cycles;
  - LDR: 5 cycles;
  - STR: 4 cycles;
  - B: 3 cycles.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD or MEMWR, and in every non-memory state.
  - Increments each cycle a memory state is held with MemReady=0 and saturates at WAIT_MAX.
  - If the count equals WAIT_MAX and MemReady=0, the next state is FAULT.
  - MemReady=1 in the same cycle the count reaches WAIT_MAX completes the access normally (ready wins).
- Downstream condition logic registers CondEx one cycle, so the FSM sets up each write one state ahead:
  - MEMADR before MEMWR;
  - EXECUTE before ALUWB;
  - DECODE before BRANCH.
  - The FSM never asserts RegW, MemW or Branch in the state immediately after FETCH.
- Reset asserted mid-instruction aborts immediately with no further strobes; the next instruction begins with FETCH after release.

Test Plan:
- Reset low 3 cycles then high; MemReady=1; Op=00, Funct=000000 → State 0,1,6,8,0. RegW=1 only in state 8. IRWrite=NextPC=1 only in cycle 0. FlagEn=1 only in state 6.
- LDR: Op=01, Funct=011001, MemReady low 2 cycles in MEMRD → State 0,1,2,3,3,3,4,0. MemReq=1 in all three state-3 cycles; RegW=1 with ResultSrc=01 in state 4.
- STR: Op=01, Funct=011000 → State 0,1,2,5,0. MemW=1 and AdrSrc=1 in state 5. RegW never asserted.
- B: Op=10 → State 0,1,9,0. Branch=1, ALUSrcB=01, ResultSrc=10 in state 9.
- Watchdog with WAIT_MAX=3 and MemReady held 0 in FETCH → FAULT (10) on the 4th clock. Fault stays 1 and all strobes stay 0 under any input until reset low. Op=11 in DECODE also → FAULT.
- Boundary: with WAIT_MAX=3, MemReady=1 exactly when the count is 3 → DECODE, not FAULT. Reset low mid-MEMWR → MemW drops to 0 asynchronously and State=0 immediately.
